cache_replacement_unit: RTL and testbench
=========================================

Name: cache_replacement_unit

Overview:
Parametrised successor to the per-set pseudo-LRU replacement logic used by the L1/L2 caches.
- Generalises the tree-PLRU to any power-of-two way count up to 16.
- Prefers invalid ways on fill and supports explicit invalidation, which moves a way to the LRU position.
- Self-initialises the flag array after reset.
- Sits beside the tag stage; drives the way select for line fills.

Parameters:
NUM_SETS, 64, number of cache sets (power of two, >=1)
NUM_WAYS, 4, associativity; 1, 2, 4, 8 or 16
SET_INDEX_WIDTH, $clog2(NUM_SETS), set index width (min 1)
WAY_INDEX_WIDTH, $clog2(NUM_WAYS), way index width (min 1)

Ports:
clk  in  1  clock; the only clock in the block
reset  in  1  synchronous, active-high
init_done  out  1  high once the flag array has been cleared
fill_en  in  1  request a victim for set fill_set
fill_set  in  SET_INDEX_WIDTH  set being filled
fill_valid  in  NUM_WAYS  valid bits of fill_set, same cycle as fill_en
fill_way  out  WAY_INDEX_WIDTH  victim way, valid the cycle after fill_en
access_en  in  1  tag lookup started on access_set
access_set  in  SET_INDEX_WIDTH  set looked up
update_en  in  1  hit; move update_way to MRU (cycle after access_en)
update_way  in  WAY_INDEX_WIDTH  way that hit
invalidate_en  in  1  move invalidate_way of invalidate_set to LRU
invalidate_set  in  SET_INDEX_WIDTH  set of invalidated line
invalidate_way  in  WAY_INDEX_WIDTH  way of invalidated line

Behaviour:
- Flag storage: one sram_1r1w, NUM_WAYS-1 bits per set, READ_DURING_WRITE NEW_DATA. For NUM_WAYS=1, width is 1 and always 0.
- Tree encoding: heap order, node n has children 2n and 2n+1, root n=1, flag bit n-1. A 0 means the LRU is in the left subtree.
- Victim: walk from the root following the flags.
- MRU update: set each node on the way's path to point away from it.
- LRU update (invalidate): set each node on the path to point toward it.
- Sequencing: clear-sweep state machine (INIT, RUN), then a 2-stage pipeline.
  - Stage 1: read the flags.
  - Stage 2: compute, then write back on the next edge via the registered set, op and way.
- States: INIT and RUN.
  - reset (any cycle, including mid-operation) -> INIT; init counter=0; init_done=0; pipeline op cleared to NONE.
  - INIT: write zero flags to set[counter] each cycle, counter++.
  - After writing set NUM_SETS-1 -> RUN; init_done=1 from the following cycle. Total: NUM_SETS cycles after reset deasserts.
  - INIT: fill_en, access_en, update_en and invalidate_en are ignored. fill_way=0 while init_done=0.
- Read-port priority (RUN): fill_en > invalidate_en > access_en. Read set is muxed accordingly.
  - A lower-priority request colliding with a higher one is dropped.
  - A dropped access means a following update_en is ignored.
- Fill, cycle after fill_en:
  - If any bit of the registered fill_valid is 0, fill_way = lowest-index invalid way.
  - Otherwise fill_way = tree victim.
  - In both cases fill_way is written as MRU.
- Update: update_en is honoured only if the previous cycle's read was an access. Otherwise it is ignored; simulation assertion.
- Invalidate: 1-cycle read, LRU write on the next edge.
- One write per cycle, from stage 2 only.
- Back-to-back ops on the same set see the new flags via NEW_DATA bypass. No stall needed.
- fill_way is combinational from the stage-2 register and the SRAM output. It is only meaningful the cycle after fill_en.
- NUM_WAYS=1: fill_way=0, no state; the INIT sweep still runs so init_done timing is uniform.
- Elaboration check: NUM_WAYS power of two, <=16. Otherwise $display and $finish.

Decomposition:
- defines package: lru_op_t enum (NONE, FILL, ACCESS, INVALIDATE) and MAX_CACHE_WAYS=16.
- Sub-module cache_plru_tree (combinational, parametrised by NUM_WAYS), built with a generate loop over tree levels. It provides:
  - flags -> victim way
  - (flags, way, to_mru) -> new flags
- The top level holds the init FSM, pipeline registers and SRAM.

Test Plan:
- Init: NUM_SETS=4; reset 1 cycle, then release -> init_done=0 for 4 cycles, 1 on 5th; fill_en asserted during INIT causes no write.
- PLRU order: 4 ways, all valid; four back-to-back fills to set 3 -> fill_way 0, 2, 1, 3; then a fifth fill -> 0.
- Invalid preference: fill set 5 with fill_valid=4'b1011 -> fill_way=2 regardless of flags; fill_valid=4'b0000 -> 0.
- Hit/invalidate: access set 1, update_way=0 -> next fill of set 1 returns 2. Then invalidate way 3 of set 1 -> next fill returns 3.
- Collisions:
  - fill_en and access_en same cycle (set 2 vs 6), update_en=1 next cycle -> set 6 flags unchanged.
  - invalidate_en with fill_en -> invalidate dropped.
  - update_en without a prior access -> ignored, assertion fires.
- Reset mid-run and 16 ways:
  - Assert reset between fill_en and fill_way -> no write occurs; INIT reruns; afterwards the first fill of any set returns 0.
  - NUM_WAYS=16: 16 fills to one set visit every way exactly once.

Source files
------------

// File: rtl/cache_replacement_unit_pkg.sv
// Shared types and limits for the cache replacement unit.
package cache_replacement_unit_pkg;

    localparam int unsigned MAX_CACHE_WAYS = 16;

    // Operation carried from the read stage into the compute/write stage
    typedef enum logic [1:0] {
        NONE,
        FILL,
        ACCESS,
        INVALIDATE
    } lru_op_t;

    // Flag-array clear sweep, then normal operation
    typedef enum logic {
        INIT,
        RUN
    } init_state_t;

endpackage

// File: rtl/cache_replacement_unit_plru_tree.sv
// Combinational tree-PLRU helper: victim walk and MRU/LRU path update.
// Heap order: node n has children 2n and 2n+1, root is node 1, flag bit n-1.
// A 0 flag means the LRU way lies in the left subtree.
module cache_plru_tree
    import cache_replacement_unit_pkg::*;
#(
    parameter int NUM_WAYS        = 4,
    parameter int WAY_INDEX_WIDTH = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    parameter int FLAG_WIDTH      = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1
) (
    input  logic [FLAG_WIDTH-1:0]      i_flags,
    input  logic [WAY_INDEX_WIDTH-1:0] i_way,
    input  logic                       i_to_mru,
    output logic [WAY_INDEX_WIDTH-1:0] o_victim,
    output logic [FLAG_WIDTH-1:0]      o_new_flags
);

    if (NUM_WAYS == 1) begin : g_single
        logic w_unused_inputs;
        assign w_unused_inputs = ^{i_flags, i_way, i_to_mru};
        assign o_victim        = '0;
        assign o_new_flags     = '0;
    end else begin : g_tree
        localparam int LEVELS = $clog2(NUM_WAYS);
        localparam int NODE_W = LEVELS + 1;

        // Flags shifted so that bit n is the flag of heap node n
        logic [NUM_WAYS-1:0] w_flags_ext;
        logic [NODE_W-1:0]   w_node      [LEVELS+1];
        logic [LEVELS-1:0]   w_path_node [LEVELS];
        logic                w_path_bit  [LEVELS];

        assign w_flags_ext = {i_flags, 1'b0};
        assign w_node[0]   = NODE_W'(1);

        for (genvar l = 0; l < LEVELS; l++) begin : g_level
            // Victim walk: descend toward the side the flag points at
            assign w_node[l+1] = {w_node[l][LEVELS-1:0], w_flags_ext[w_node[l][LEVELS-1:0]]};
            // Node on the path of i_way at this level, and the branch taken there
            assign w_path_node[l] = LEVELS'(1 << l) | LEVELS'(i_way >> (LEVELS - l));
            // MRU points away from the way, LRU points toward it
            assign w_path_bit[l]  = i_way[LEVELS-1-l] ^ i_to_mru;
        end

        assign o_victim = WAY_INDEX_WIDTH'(w_node[LEVELS] - NODE_W'(NUM_WAYS));

        // Overwrite the flags of every node along the path of i_way
        always_comb begin
            o_new_flags = i_flags;
            for (int unsigned l = 0; l < LEVELS; l++) begin
                for (int unsigned n = 1; n < NUM_WAYS; n++) begin
                    if (w_path_node[l] == LEVELS'(n)) begin
                        o_new_flags[n-1] = w_path_bit[l];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/cache_replacement_unit.sv
// Per-set tree-PLRU replacement unit: clear sweep after reset, then a
// two-stage read / compute-and-write-back pipeline on one 1R1W flag array.
module cache_replacement_unit
    import cache_replacement_unit_pkg::*;
#(
    parameter int NUM_SETS        = 64,
    parameter int NUM_WAYS        = 4,
    parameter int SET_INDEX_WIDTH = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
    parameter int WAY_INDEX_WIDTH = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       init_done,
    input  logic                       fill_en,
    input  logic [SET_INDEX_WIDTH-1:0] fill_set,
    input  logic [NUM_WAYS-1:0]        fill_valid,
    output logic [WAY_INDEX_WIDTH-1:0] fill_way,
    input  logic                       access_en,
    input  logic [SET_INDEX_WIDTH-1:0] access_set,
    input  logic                       update_en,
    input  logic [WAY_INDEX_WIDTH-1:0] update_way,
    input  logic                       invalidate_en,
    input  logic [SET_INDEX_WIDTH-1:0] invalidate_set,
    input  logic [WAY_INDEX_WIDTH-1:0] invalidate_way
);

    localparam int FLAG_WIDTH = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;
    localparam int MEM_DEPTH  = 2 ** SET_INDEX_WIDTH;

    if (NUM_WAYS < 1 || NUM_WAYS > MAX_CACHE_WAYS || (NUM_WAYS & (NUM_WAYS - 1)) != 0) begin : g_bad_ways
        $fatal(1, "cache_replacement_unit: NUM_WAYS must be a power of two no larger than 16");
    end

    init_state_t                r_state;
    logic [SET_INDEX_WIDTH-1:0] r_init_cnt;
    logic                       r_init_done;

    lru_op_t                    r_op;
    logic [SET_INDEX_WIDTH-1:0] r_set;
    logic [WAY_INDEX_WIDTH-1:0] r_way;
    logic [NUM_WAYS-1:0]        r_valid;

    logic [FLAG_WIDTH-1:0]      r_mem [MEM_DEPTH];
    logic [FLAG_WIDTH-1:0]      r_rdata;

    lru_op_t                    w_rd_op;
    logic [SET_INDEX_WIDTH-1:0] w_rd_set;
    logic                       w_we;
    logic [SET_INDEX_WIDTH-1:0] w_waddr;
    logic [FLAG_WIDTH-1:0]      w_wdata;
    logic [WAY_INDEX_WIDTH-1:0] w_victim;
    logic [WAY_INDEX_WIDTH-1:0] w_first_invalid;
    logic                       w_any_invalid;
    logic [WAY_INDEX_WIDTH-1:0] w_fill_sel;
    logic [WAY_INDEX_WIDTH-1:0] w_tree_way;
    logic [FLAG_WIDTH-1:0]      w_new_flags;

    // Clear sweep FSM: one set per cycle, then RUN with init_done registered
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= INIT;
            r_init_cnt  <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == SET_INDEX_WIDTH'(NUM_SETS - 1)) begin
                        r_state     <= RUN;
                        r_init_done <= 1'b1;
                        r_init_cnt  <= '0;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    // Read-port arbitration: fill beats invalidate beats access; losers are dropped
    always_comb begin
        w_rd_op  = NONE;
        w_rd_set = access_set;
        if (r_state == RUN) begin
            if (fill_en) begin
                w_rd_op  = FILL;
                w_rd_set = fill_set;
            end else if (invalidate_en) begin
                w_rd_op  = INVALIDATE;
                w_rd_set = invalidate_set;
            end else if (access_en) begin
                w_rd_op  = ACCESS;
                w_rd_set = access_set;
            end
        end
    end

    // Stage-2 registers: which op, set and way the next write-back belongs to
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op <= NONE;
        end else begin
            r_op <= w_rd_op;
        end
        r_set   <= w_rd_set;
        r_way   <= invalidate_way;
        r_valid <= fill_valid;
    end

    // Fill choice: lowest invalid way if any, otherwise the tree victim
    always_comb begin
        w_any_invalid   = 1'b0;
        w_first_invalid = '0;
        for (int unsigned i = NUM_WAYS; i > 0; i--) begin
            if (!r_valid[i-1]) begin
                w_any_invalid   = 1'b1;
                w_first_invalid = WAY_INDEX_WIDTH'(i - 1);
            end
        end
        w_fill_sel = w_any_invalid ? w_first_invalid : w_victim;
    end

    // Way whose path is rewritten by the stage-2 write-back
    always_comb begin
        case (r_op)
            ACCESS:     w_tree_way = update_way;
            INVALIDATE: w_tree_way = r_way;
            default:    w_tree_way = w_fill_sel;
        endcase
    end

    cache_plru_tree #(
        .NUM_WAYS        (NUM_WAYS),
        .WAY_INDEX_WIDTH (WAY_INDEX_WIDTH),
        .FLAG_WIDTH      (FLAG_WIDTH)
    ) u_tree (
        .i_flags     (r_rdata),
        .i_way       (w_tree_way),
        .i_to_mru    (r_op != INVALIDATE),
        .o_victim    (w_victim),
        .o_new_flags (w_new_flags)
    );

    // Single write source: the clear sweep during INIT, stage 2 during RUN
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_set;
        w_wdata = w_new_flags;
        if (!reset) begin
            if (r_state == INIT) begin
                w_we    = 1'b1;
                w_waddr = r_init_cnt;
                w_wdata = '0;
            end else begin
                case (r_op)
                    FILL:       w_we = 1'b1;
                    ACCESS:     w_we = update_en;
                    INVALIDATE: w_we = 1'b1;
                    default:    w_we = 1'b0;
                endcase
            end
        end
    end

    // Flag array with registered read; a same-edge write to the read set is forwarded
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        r_rdata <= (w_we && w_waddr == w_rd_set) ? w_wdata : r_mem[w_rd_set];
    end

    // An update only makes sense right after an access read
    always_ff @(posedge clk) begin
        if (!reset && r_state == RUN && update_en) begin
            assert (r_op == ACCESS)
                else $warning("cache_replacement_unit: update_en ignored, previous read was not an access");
        end
    end

    assign init_done = r_init_done;
    assign fill_way  = r_init_done ? w_fill_sel : '0;

endmodule

// File: tb/tb_cache_replacement_unit.sv
// Directed bench: an 8-set/4-way instance (A) and a 4-set/16-way instance (B).
module tb_cache_replacement_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic       a_init_done, a_fill_en, a_access_en, a_update_en, a_inv_en;
    logic [2:0] a_fill_set, a_access_set, a_inv_set;
    logic [3:0] a_fill_valid;
    logic [1:0] a_fill_way, a_update_way, a_inv_way;

    logic        b_init_done, b_fill_en, b_access_en, b_update_en, b_inv_en;
    logic [1:0]  b_fill_set, b_access_set, b_inv_set;
    logic [15:0] b_fill_valid;
    logic [3:0]  b_fill_way, b_update_way, b_inv_way;

    cache_replacement_unit #(.NUM_SETS(8), .NUM_WAYS(4)) dut_a (
        .clk(clk), .reset(reset), .init_done(a_init_done),
        .fill_en(a_fill_en), .fill_set(a_fill_set), .fill_valid(a_fill_valid), .fill_way(a_fill_way),
        .access_en(a_access_en), .access_set(a_access_set),
        .update_en(a_update_en), .update_way(a_update_way),
        .invalidate_en(a_inv_en), .invalidate_set(a_inv_set), .invalidate_way(a_inv_way)
    );

    cache_replacement_unit #(.NUM_SETS(4), .NUM_WAYS(16)) dut_b (
        .clk(clk), .reset(reset), .init_done(b_init_done),
        .fill_en(b_fill_en), .fill_set(b_fill_set), .fill_valid(b_fill_valid), .fill_way(b_fill_way),
        .access_en(b_access_en), .access_set(b_access_set),
        .update_en(b_update_en), .update_way(b_update_way),
        .invalidate_en(b_inv_en), .invalidate_set(b_inv_set), .invalidate_way(b_inv_way)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    typedef struct {
        logic [2:0] set;
        logic [3:0] valid;
        int         exp_way;
    } fill_vec_t;

    fill_vec_t fv[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [15:0] seen;
        int distinct;

        // PLRU order on set 3, invalid preference on set 5, tree state after it
        fv[0] = '{3'd3, 4'b1111, 0};
        fv[1] = '{3'd3, 4'b1111, 2};
        fv[2] = '{3'd3, 4'b1111, 1};
        fv[3] = '{3'd3, 4'b1111, 3};
        fv[4] = '{3'd3, 4'b1111, 0};
        fv[5] = '{3'd5, 4'b1011, 2};
        fv[6] = '{3'd5, 4'b0000, 0};
        fv[7] = '{3'd5, 4'b1111, 3};
        fv[8] = '{3'd3, 4'b1111, 2};

        reset = 1'b1;
        a_fill_en = 1'b1; a_fill_set = 3'd0; a_fill_valid = 4'b1111;
        a_access_en = 1'b0; a_access_set = '0; a_update_en = 1'b0; a_update_way = '0;
        a_inv_en = 1'b0; a_inv_set = '0; a_inv_way = '0;
        b_fill_en = 1'b1; b_fill_set = 2'd0; b_fill_valid = '1;
        b_access_en = 1'b0; b_access_set = '0; b_update_en = 1'b0; b_update_way = '0;
        b_inv_en = 1'b0; b_inv_set = '0; b_inv_way = '0;

        repeat (2) @(negedge clk);
        check("reset_a_init_done", a_init_done, 0);
        check("reset_b_init_done", b_init_done, 0);
        check("reset_a_fill_way", a_fill_way, 0);
        reset = 1'b0;

        // Init sweep timing; fills held high during INIT must leave no trace
        for (int k = 0; k <= 9; k++) begin
            if (k <= 8) check($sformatf("init_a_k%0d", k), a_init_done, (k >= 8) ? 1 : 0);
            check($sformatf("init_b_k%0d", k), b_init_done, (k >= 4) ? 1 : 0);
            if (k < 8) check($sformatf("init_a_way_k%0d", k), a_fill_way, 0);
            if (k == 5) begin
                check("init_b_first_fill", b_fill_way, 0);
                b_fill_en = 1'b0;
            end
            if (k == 9) begin
                check("init_a_first_fill", a_fill_way, 0);
                a_fill_en = 1'b0;
            end
            @(negedge clk);
        end

        // Back-to-back fills from the vector table
        for (int i = 0; i < 9; i++) begin
            a_fill_en = 1'b1; a_fill_set = fv[i].set; a_fill_valid = fv[i].valid;
            @(negedge clk);
            check($sformatf("fill_tbl_%0d", i), a_fill_way, fv[i].exp_way);
        end
        a_fill_en = 1'b0; a_fill_valid = 4'b1111;

        // Hit moves way 0 to MRU, invalidate moves way 3 to LRU
        a_access_en = 1'b1; a_access_set = 3'd1;
        @(negedge clk);
        a_access_en = 1'b0; a_update_en = 1'b1; a_update_way = 2'd0;
        @(negedge clk);
        a_update_en = 1'b0; a_fill_en = 1'b1; a_fill_set = 3'd1;
        @(negedge clk);
        check("hit_then_fill", a_fill_way, 2);
        a_fill_en = 1'b0; a_inv_en = 1'b1; a_inv_set = 3'd1; a_inv_way = 2'd3;
        @(negedge clk);
        a_inv_en = 1'b0; a_fill_en = 1'b1; a_fill_set = 3'd1;
        @(negedge clk);
        check("inv_then_fill", a_fill_way, 3);
        a_fill_en = 1'b0;

        // Access on set 6 collides with fill on set 2; the following update is dropped
        a_fill_en = 1'b1; a_fill_set = 3'd2; a_access_en = 1'b1; a_access_set = 3'd6;
        @(negedge clk);
        check("collide_fill_set2", a_fill_way, 0);
        a_fill_en = 1'b0; a_access_en = 1'b0; a_update_en = 1'b1; a_update_way = 2'd0;
        @(negedge clk);
        a_update_en = 1'b0; a_fill_en = 1'b1; a_fill_set = 3'd6;
        @(negedge clk);
        check("collide_set6_untouched", a_fill_way, 0);
        a_fill_en = 1'b0;

        // Invalidate colliding with fill is dropped
        a_fill_en = 1'b1; a_fill_set = 3'd7;
        @(negedge clk);
        check("prep_set7", a_fill_way, 0);
        a_fill_set = 3'd4; a_inv_en = 1'b1; a_inv_set = 3'd7; a_inv_way = 2'd0;
        @(negedge clk);
        check("inv_collide_fill_set4", a_fill_way, 0);
        a_inv_en = 1'b0; a_fill_set = 3'd7;
        @(negedge clk);
        check("inv_dropped_set7", a_fill_way, 2);
        a_fill_en = 1'b0;

        // Update with no preceding access is ignored
        a_inv_en = 1'b1; a_inv_set = 3'd0; a_inv_way = 2'd1;
        @(negedge clk);
        a_inv_en = 1'b0; a_update_en = 1'b1; a_update_way = 2'd0;
        @(negedge clk);
        a_update_en = 1'b0; a_fill_en = 1'b1; a_fill_set = 3'd0;
        @(negedge clk);
        check("update_without_access", a_fill_way, 1);
        a_fill_en = 1'b0;

        // Reset between fill_en and its result; sweep reruns
        a_fill_en = 1'b1; a_fill_set = 3'd3;
        @(negedge clk);
        a_fill_en = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (!a_init_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rerun_init_cycles", n, 8);
        a_fill_en = 1'b1; a_fill_set = 3'd3;
        @(negedge clk);
        check("post_reset_set3", a_fill_way, 0);
        a_fill_set = 3'd5;
        @(negedge clk);
        check("post_reset_set5", a_fill_way, 0);
        a_fill_set = 3'd1;
        @(negedge clk);
        check("post_reset_set1", a_fill_way, 0);
        a_fill_en = 1'b0;

        // 16-way: sixteen fills visit every way once, the seventeenth wraps to 0
        seen = '0;
        b_fill_en = 1'b1; b_fill_set = 2'd2; b_fill_valid = '1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) check("w16_first", b_fill_way, 0);
            seen[b_fill_way] = 1'b1;
        end
        @(negedge clk);
        check("w16_wrap", b_fill_way, 0);
        b_fill_en = 1'b0;
        distinct = $countones(seen);
        check("w16_distinct", distinct, 16);

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
